lru_writeback_cache: RTL
========================

LRU_WRITEBACK_CACHE -- requirements
Module: lru_writeback_cache

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, is the byte address width.
REQ-002 Parameter SETS, default 4, is the number of sets; it SHALL be a power of 2 and at least 2.
REQ-003 Parameter WAYS, default 4, is the associativity; it SHALL be a power of 2 and at least 2.
REQ-004 Parameter CACHE_LINE_SIZE, default 32, is the line width in bits; it SHALL be a multiple of 8, and one line is one word.
REQ-005 Parameter TAG_WIDTH, default ADDRESS_WIDTH-($clog2(SETS)+$clog2(CACHE_LINE_SIZE/8)), is the tag width.
REQ-006 clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 reqValid_CPU  in  1  CPU request valid.
REQ-009 reqReady_CPU  out  1  cache can accept a request.
REQ-010 address_in_CPU  in  ADDRESS_WIDTH  request byte address.
REQ-011 data_in_CPU  in  CACHE_LINE_SIZE  write data.
REQ-012 strobe_CPU  in  CACHE_LINE_SIZE/8  write byte enables.
REQ-013 wen_CPU  in  1  1 = write, 0 = read.
REQ-014 respValid_CPU  out  1  one-cycle response pulse.
REQ-015 data_out_CPU  out  CACHE_LINE_SIZE  line contents after the access.
REQ-016 hit_CPU  out  1  request hit; valid with respValid_CPU.
REQ-017 reqValid_MEM  out  1  memory request, held until acknowledged.
REQ-018 reqAddress_MEM  out  ADDRESS_WIDTH  line-aligned memory address.
REQ-019 reqDataOut_MEM  out  CACHE_LINE_SIZE  write-back data.
REQ-020 reqWen_MEM  out  1  1 = write-back, 0 = refill read.
REQ-021 reqStrobe_MEM  out  CACHE_LINE_SIZE/8  all ones on write-back, all zeros on refill.
REQ-022 respValid_MEM  in  1  memory acknowledge; sampled only while reqValid_MEM=1.
REQ-023 respDataIn_MEM  in  CACHE_LINE_SIZE  refill data, valid with respValid_MEM.

Function
REQ-024 Address decode SHALL be: offset = low $clog2(CACHE_LINE_SIZE/8) bits (ignored); index = next $clog2(SETS) bits; tag = top TAG_WIDTH bits.
REQ-025 Storage SHALL be register-based: per set and way, a data line, a tag, a valid bit, a dirty bit and a $clog2(WAYS)-bit age.
REQ-026 The FSM SHALL have states IDLE, LOOKUP, WRITEBACK, REFILL and RESPOND; reqReady_CPU=1 only in IDLE.
REQ-027 In IDLE, reqValid_CPU&reqReady_CPU SHALL capture address, data, strobe and wen, then move to LOOKUP; reqValid_CPU outside IDLE SHALL be ignored.
REQ-028 LOOKUP, hit (tag match and valid): for a write, merge bytes where strobe=1 and set dirty; update LRU; go to RESPOND with hit_CPU=1.
REQ-029 LOOKUP, miss: choose the victim as the lowest-index invalid way, else the way with age WAYS-1; go to WRITEBACK if the victim is valid&dirty, else REFILL.
REQ-030 WRITEBACK: reqValid_MEM=1, reqWen_MEM=1, reqAddress_MEM={victim tag,index,0}, reqDataOut_MEM=victim line; on respValid_MEM go to REFILL.
REQ-031 REFILL: reqValid_MEM=1, reqWen_MEM=0, reqAddress_MEM={tag,index,0}; on respValid_MEM install respDataIn_MEM, set valid=1 and dirty=0, and merge write bytes (dirty=1 if write); update LRU; go to RESPOND with hit_CPU=0.
REQ-032 A same-cycle respValid_MEM (acknowledge in the first request cycle) SHALL be legal; respValid_MEM while reqValid_MEM=0 SHALL be ignored.
REQ-033 RESPOND SHALL drive respValid_CPU=1 for exactly one cycle with data_out_CPU = the post-access line, then return to IDLE.
REQ-034 Hit latency: a request accepted on edge T SHALL produce respValid_CPU in the cycle after edge T+2; the bus is idle during a hit.
REQ-035 LRU update on access to way w with age a: every way in the set with age<a increments, and w gets age 0; ages in a set always form a permutation of 0..WAYS-1.
REQ-036 Outside WRITEBACK and REFILL, reqValid_MEM SHALL be 0.

Reset
REQ-037 While rst=1 at a clock edge: state goes to IDLE; all valid and dirty bits clear; age of way i is set to i.
REQ-038 Outputs after reset: reqReady_CPU=1; respValid_CPU, hit_CPU, reqValid_MEM, reqWen_MEM=0; data, address and strobe outputs = 0.
REQ-039 Reset mid-operation SHALL abort any pending memory transaction (reqValid_MEM=0 after the edge) and discard dirty data without write-back.

Verification (WAYS=4, SETS=4; index = addr[3:2])
REQ-040 After reset, read 0x10, memory returns 0xDEADBEEF -> REFILL at 0x10, resp data 0xDEADBEEF, hit=0; reread 0x10 -> hit=1 in 2 cycles, no memory traffic.
REQ-041 Write 0x10 data 0x000000AA strobe 0001 -> hit=1, data_out 0xDEADBEAA, line dirty.
REQ-042 Clean reads of 0x10, 0x20, 0x30, 0x40, then 0x10, then 0x50 -> the line for 0x20 is evicted with no write-back; reading 0x10 again hits.
REQ-043 Write 0x20 with 0x11223344 strobe 1111, then force its eviction -> WRITEBACK at 0x20 with data 0x11223344 and strobe 1111 precedes the REFILL read.
REQ-044 Write miss to 0x60, data 0x12345678 strobe 1100, memory returns 0xAAAAAAAA -> resp 0x1234AAAA, hit=0, line dirty.
REQ-045 Assert rst during REFILL wait -> reqValid_MEM=0 and reqReady_CPU=1 the next cycle; a following read of 0x10 misses.

Source files
------------

// File: rtl/lru_writeback_cache.sv
// Set-associative write-back cache with true-LRU replacement and a single
// outstanding memory transaction (write-back of a dirty victim, then refill).
module lru_writeback_cache #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int SETS            = 4,
  parameter int WAYS            = 4,
  parameter int CACHE_LINE_SIZE = 32,
  parameter int TAG_WIDTH       = ADDRESS_WIDTH - ($clog2(SETS) + $clog2(CACHE_LINE_SIZE/8))
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reqValid_CPU,
  output logic                         reqReady_CPU,
  input  logic [ADDRESS_WIDTH-1:0]     address_in_CPU,
  input  logic [CACHE_LINE_SIZE-1:0]   data_in_CPU,
  input  logic [CACHE_LINE_SIZE/8-1:0] strobe_CPU,
  input  logic                         wen_CPU,
  output logic                         respValid_CPU,
  output logic [CACHE_LINE_SIZE-1:0]   data_out_CPU,
  output logic                         hit_CPU,
  output logic                         reqValid_MEM,
  output logic [ADDRESS_WIDTH-1:0]     reqAddress_MEM,
  output logic [CACHE_LINE_SIZE-1:0]   reqDataOut_MEM,
  output logic                         reqWen_MEM,
  output logic [CACHE_LINE_SIZE/8-1:0] reqStrobe_MEM,
  input  logic                         respValid_MEM,
  input  logic [CACHE_LINE_SIZE-1:0]   respDataIn_MEM
);

  localparam int OFFSET_BITS = $clog2(CACHE_LINE_SIZE/8);
  localparam int INDEX_BITS  = $clog2(SETS);
  localparam int WAY_BITS    = $clog2(WAYS);
  localparam int STRB_W      = CACHE_LINE_SIZE/8;
  localparam int LINE_ADDR_W = ADDRESS_WIDTH - OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  typedef logic [WAYS-1:0][WAY_BITS-1:0] ageSet_t;

  state_t state_r, nextState_s;

  logic [CACHE_LINE_SIZE-1:0] lineData_r [SETS][WAYS];
  logic [TAG_WIDTH-1:0]       lineTag_r  [SETS][WAYS];
  logic [WAYS-1:0]            valid_r    [SETS];
  logic [WAYS-1:0]            dirty_r    [SETS];
  ageSet_t                    age_r      [SETS];

  logic [LINE_ADDR_W-1:0]     reqLine_r;
  logic [CACHE_LINE_SIZE-1:0] reqData_r;
  logic [STRB_W-1:0]          reqStrb_r;
  logic                       reqWen_r;
  logic [WAY_BITS-1:0]        victim_r;
  logic                       respHit_r;
  logic [CACHE_LINE_SIZE-1:0] respLine_r;

  logic [INDEX_BITS-1:0]      reqIndex_s;
  logic [TAG_WIDTH-1:0]       reqTag_s;
  logic                       hit_s;
  logic [WAY_BITS-1:0]        hitWay_s;
  logic                       anyInvalid_s;
  logic [WAY_BITS-1:0]        invalidWay_s;
  logic [WAY_BITS-1:0]        lruWay_s;
  logic [WAY_BITS-1:0]        victimWay_s;
  logic                       victimDirty_s;
  logic [WAY_BITS-1:0]        memWay_s;
  logic [CACHE_LINE_SIZE-1:0] hitLine_s;
  logic [CACHE_LINE_SIZE-1:0] fillLine_s;
  logic                       unusedOffset_s;

  function automatic logic [CACHE_LINE_SIZE-1:0] mergeBytes(
    input logic [CACHE_LINE_SIZE-1:0] oldLine,
    input logic [CACHE_LINE_SIZE-1:0] newLine,
    input logic [STRB_W-1:0]          strb
  );
    logic [CACHE_LINE_SIZE-1:0] res;
    res = oldLine;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = newLine[8*b +: 8];
      end else begin
        res[8*b +: 8] = oldLine[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Accessed way becomes youngest; every way younger than it ages by one.
  function automatic ageSet_t lruTouch(input ageSet_t ages, input logic [WAY_BITS-1:0] way);
    ageSet_t res;
    res = ages;
    for (int j = 0; j < WAYS; j++) begin
      if (j == int'(way)) begin
        res[j] = '0;
      end else if (ages[j] < ages[way]) begin
        res[j] = ages[j] + 1'b1;
      end else begin
        res[j] = ages[j];
      end
    end
    return res;
  endfunction

  assign unusedOffset_s = ^address_in_CPU[OFFSET_BITS-1:0];
  assign reqIndex_s     = reqLine_r[INDEX_BITS-1:0];
  assign reqTag_s       = reqLine_r[INDEX_BITS +: TAG_WIDTH];

  // Tag compare, victim selection and merged line images for the captured request.
  always_comb begin
    hit_s        = 1'b0;
    hitWay_s     = '0;
    anyInvalid_s = 1'b0;
    invalidWay_s = '0;
    lruWay_s     = '0;
    // Descending scan so the lowest-index invalid way wins.
    for (int i = WAYS-1; i >= 0; i--) begin
      if (valid_r[reqIndex_s][i] && (lineTag_r[reqIndex_s][i] == reqTag_s)) begin
        hit_s    = 1'b1;
        hitWay_s = WAY_BITS'(i);
      end else if (!valid_r[reqIndex_s][i]) begin
        anyInvalid_s = 1'b1;
        invalidWay_s = WAY_BITS'(i);
      end else if (age_r[reqIndex_s][i] == WAY_BITS'(WAYS-1)) begin
        lruWay_s = WAY_BITS'(i);
      end else begin
        lruWay_s = lruWay_s;
      end
    end
    victimWay_s   = anyInvalid_s ? invalidWay_s : lruWay_s;
    victimDirty_s = valid_r[reqIndex_s][victimWay_s] && dirty_r[reqIndex_s][victimWay_s];
    memWay_s      = (state_r == LOOKUP) ? victimWay_s : victim_r;
    hitLine_s     = reqWen_r ? mergeBytes(lineData_r[reqIndex_s][hitWay_s], reqData_r, reqStrb_r)
                             : lineData_r[reqIndex_s][hitWay_s];
    fillLine_s    = reqWen_r ? mergeBytes(respDataIn_MEM, reqData_r, reqStrb_r) : respDataIn_MEM;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decode.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (reqValid_CPU) begin
          nextState_s = LOOKUP;
        end else begin
          nextState_s = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          nextState_s = RESPOND;
        end else if (victimDirty_s) begin
          nextState_s = WRITEBACK;
        end else begin
          nextState_s = REFILL;
        end
      end
      WRITEBACK: begin
        if (respValid_MEM) begin
          nextState_s = REFILL;
        end else begin
          nextState_s = WRITEBACK;
        end
      end
      REFILL: begin
        if (respValid_MEM) begin
          nextState_s = RESPOND;
        end else begin
          nextState_s = REFILL;
        end
      end
      RESPOND: nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Registered CPU and memory outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      reqReady_CPU   <= 1'b1;
      respValid_CPU  <= 1'b0;
      hit_CPU        <= 1'b0;
      data_out_CPU   <= '0;
      reqValid_MEM   <= 1'b0;
      reqWen_MEM     <= 1'b0;
      reqStrobe_MEM  <= '0;
      reqAddress_MEM <= '0;
      reqDataOut_MEM <= '0;
    end else begin
      reqReady_CPU  <= (nextState_s == IDLE);
      respValid_CPU <= (state_r == RESPOND);
      hit_CPU       <= (state_r == RESPOND) && respHit_r;
      if (state_r == RESPOND) begin
        data_out_CPU <= respLine_r;
      end
      case (nextState_s)
        WRITEBACK: begin
          reqValid_MEM   <= 1'b1;
          reqWen_MEM     <= 1'b1;
          reqStrobe_MEM  <= '1;
          reqAddress_MEM <= {lineTag_r[reqIndex_s][memWay_s], reqIndex_s, {OFFSET_BITS{1'b0}}};
          reqDataOut_MEM <= lineData_r[reqIndex_s][memWay_s];
        end
        REFILL: begin
          reqValid_MEM   <= 1'b1;
          reqWen_MEM     <= 1'b0;
          reqStrobe_MEM  <= '0;
          reqAddress_MEM <= {reqTag_s, reqIndex_s, {OFFSET_BITS{1'b0}}};
          reqDataOut_MEM <= '0;
        end
        default: begin
          reqValid_MEM   <= 1'b0;
          reqWen_MEM     <= 1'b0;
          reqStrobe_MEM  <= '0;
          reqAddress_MEM <= '0;
          reqDataOut_MEM <= '0;
        end
      endcase
    end
  end

  // Request capture plus valid/dirty/age bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_r[s][w] <= WAY_BITS'(w);
        end
      end
      reqLine_r  <= '0;
      reqData_r  <= '0;
      reqStrb_r  <= '0;
      reqWen_r   <= 1'b0;
      victim_r   <= '0;
      respHit_r  <= 1'b0;
      respLine_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (reqValid_CPU) begin
            reqLine_r <= address_in_CPU[ADDRESS_WIDTH-1:OFFSET_BITS];
            reqData_r <= data_in_CPU;
            reqStrb_r <= strobe_CPU;
            reqWen_r  <= wen_CPU;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            dirty_r[reqIndex_s][hitWay_s] <= dirty_r[reqIndex_s][hitWay_s] | reqWen_r;
            age_r[reqIndex_s]             <= lruTouch(age_r[reqIndex_s], hitWay_s);
            respHit_r                     <= 1'b1;
            respLine_r                    <= hitLine_s;
          end else begin
            victim_r  <= victimWay_s;
            respHit_r <= 1'b0;
          end
        end
        REFILL: begin
          if (respValid_MEM) begin
            valid_r[reqIndex_s][victim_r] <= 1'b1;
            dirty_r[reqIndex_s][victim_r] <= reqWen_r;
            age_r[reqIndex_s]             <= lruTouch(age_r[reqIndex_s], victim_r);
            respLine_r                    <= fillLine_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Line data and tag storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if ((state_r == LOOKUP) && hit_s && reqWen_r) begin
      lineData_r[reqIndex_s][hitWay_s] <= hitLine_s;
    end else if ((state_r == REFILL) && respValid_MEM) begin
      lineData_r[reqIndex_s][victim_r] <= fillLine_s;
      lineTag_r[reqIndex_s][victim_r]  <= reqTag_s;
    end
  end

endmodule
